// File: rtl/vgaminikbd_pkg.sv
// Shared constants for the VGA mini-keyboard terminal: default 640x480@60 raster
// timing, the 8x16 glyph cell and the 80x30 text grid.
package vgaminikbd_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int GLYPH_W      = 8;
  localparam int GLYPH_H      = 16;
  localparam int GLYPH_W_BITS = $clog2(GLYPH_W);
  localparam int GLYPH_H_BITS = $clog2(GLYPH_H);

  localparam int TEXT_COLS    = 80;
  localparam int TEXT_ROWS    = 30;
  localparam int COL_W        = $clog2(TEXT_COLS);
  localparam int ROW_W        = $clog2(TEXT_ROWS);

  function automatic int axisTotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter with sync and visible flags decoded from
// the value the counter is about to take, so all outputs describe the same position.
module vga_axis_counter import vgaminikbd_pkg::*; #(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0,
  parameter int W      = $clog2(axisTotal(ACTIVE, FP, SYNC, BP))
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         visible,
  output logic         wrap
);

  localparam int TOTAL = axisTotal(ACTIVE, FP, SYNC, BP);
  localparam int WP1   = W + 1;
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W:0]   ACTIVE_END = WP1'(ACTIVE);
  localparam logic [W:0]   SYNC_START = WP1'(ACTIVE + FP);
  localparam logic [W:0]   SYNC_END   = WP1'(ACTIVE + FP + SYNC);

  logic [W-1:0] nextCount;
  logic [W:0]   nextWide;

  assign wrap      = (count == LAST);
  assign nextCount = wrap ? '0 : count + W'(1);
  // One spare bit so a sync window ending exactly at 2^W still compares correctly.
  assign nextWide  = {1'b0, nextCount};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count   <= LAST;
      sync    <= ~POL;
      visible <= 1'b0;
    end else if (advance) begin
      count   <= nextCount;
      sync    <= (nextWide >= SYNC_START && nextWide < SYNC_END) ? POL : ~POL;
      visible <= (nextWide < ACTIVE_END);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator for the VGA text terminal: syncs, active flag, pixel
// coordinates and line/frame pulses. Define VGA_CHAR_COORD_EN for text-cell coordinates.
module vga_timing import vgaminikbd_pkg::*; #(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL  = axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL  = axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          pixEn,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          lineStart,
  output logic          frameStart
`ifdef VGA_CHAR_COORD_EN
  ,
  output logic [6:0]    charCol,
  output logic [4:0]    charRow,
  output logic [2:0]    glyphX,
  output logic [3:0]    glyphY
`endif
);

  logic hWrap, vWrap, hVisible, vVisible, vAdvance;

  assign vAdvance = pixEn & hWrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL), .W(HW)
  ) hAxis (
    .clk(clk), .resetn(resetn), .advance(pixEn),
    .count(x), .sync(hsync), .visible(hVisible), .wrap(hWrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL), .W(VW)
  ) vAxis (
    .clk(clk), .resetn(resetn), .advance(vAdvance),
    .count(y), .sync(vsync), .visible(vVisible), .wrap(vWrap)
  );

  // Both visible terms are flops loaded on the same edge, so the AND tracks x/y exactly.
  assign active = hVisible & vVisible;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      lineStart  <= vAdvance;
      frameStart <= vAdvance & vWrap;
    end
  end

`ifdef VGA_CHAR_COORD_EN
  logic [HW-1:0] xNext;
  logic [VW-1:0] yNext;

  always_comb begin
    xNext = hWrap ? '0 : x + HW'(1);
    yNext = y;
    if (hWrap) yNext = vWrap ? '0 : y + VW'(1);
  end

  // Cell coordinates follow the counters through blanking; consumers gate with active.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      charCol <= '0;
      charRow <= '0;
      glyphX  <= '0;
      glyphY  <= '0;
    end else if (pixEn) begin
      charCol <= COL_W'(32'(xNext) >> GLYPH_W_BITS);
      charRow <= ROW_W'(32'(yNext) >> GLYPH_H_BITS);
      glyphX  <= GLYPH_W_BITS'(xNext);
      glyphY  <= GLYPH_H_BITS'(yNext);
    end
  end
`endif

endmodule
